// File: rtl/ika2151_wrseq.sv
// Register-write sequencer for the IKA2151 CPU bus: buffers {addr,data} pairs
// and replays them as address/data strobes timed in phiM ticks.
module ika2151_wrseq #(
    parameter int FIFO_DEPTH     = 8,
    parameter int STB_W          = 2,
    parameter int ADDR_GAP       = 2,
    parameter int BUSY_WAIT      = 68,
    parameter bit SKIP_SAME_ADDR = 1'b1
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST,
    input  logic                          i_phiM_PCEN_n,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [7:0]                    i_wr_addr,
    input  logic [7:0]                    i_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_CS_n,
    output logic                          o_WR_n,
    output logic                          o_A0,
    output logic [7:0]                    o_D
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXC = (STB_W > ADDR_GAP) ? ((STB_W > BUSY_WAIT) ? STB_W : BUSY_WAIT)
                                             : ((ADDR_GAP > BUSY_WAIT) ? ADDR_GAP : BUSY_WAIT);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_STB  = 3'd1,
        A_GAP  = 3'd2,
        D_STB  = 3'd3,
        D_BUSY = 3'd4
    } state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_valid;
    logic [7:0]    last_addr;
    logic [7:0]    cur_data;

    logic          tick;
    logic          push;
    logic          pop;
    logic          active_nxt;
    logic [LW-1:0] level_nxt;
    logic [7:0]    head_addr;
    logic [7:0]    head_data;

    assign tick = ~i_phiM_PCEN_n;

    // Push/pop decisions and the next occupancy / activity used by the registered flags.
    always_comb begin
        push      = i_wr_valid && o_wr_ready;
        pop       = tick && (state == IDLE) && (o_level != LW'(0));
        head_addr = mem[rd_ptr][15:8];
        head_data = mem[rd_ptr][7:0];
        if (push && !pop) begin
            level_nxt = o_level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = o_level - LW'(1);
        end else begin
            level_nxt = o_level;
        end
        if (pop) begin
            active_nxt = 1'b1;
        end else if (state == IDLE) begin
            active_nxt = 1'b0;
        end else if (tick && (state == D_BUSY) && (cnt == CW'(0))) begin
            active_nxt = 1'b0;
        end else begin
            active_nxt = 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem[wr_ptr] <= {i_wr_addr, i_wr_data};
        end
    end

    // FIFO pointers, occupancy and host-side status flags run on every clock.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_wr_ready <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            o_level    <= level_nxt;
            o_wr_ready <= (level_nxt != FULL);
            o_busy     <= active_nxt || (level_nxt != LW'(0));
        end
    end

    // Bus sequencer: advances only on phiM ticks, bus pins driven straight from registers.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state      <= IDLE;
            cnt        <= '0;
            last_valid <= 1'b0;
            last_addr  <= 8'h00;
            cur_data   <= 8'h00;
            o_CS_n     <= 1'b1;
            o_WR_n     <= 1'b1;
            o_A0       <= 1'b0;
            o_D        <= 8'h00;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_data <= head_data;
                        cnt      <= CW'(STB_W - 1);
                        o_CS_n   <= 1'b0;
                        o_WR_n   <= 1'b0;
                        if (SKIP_SAME_ADDR && last_valid && (head_addr == last_addr)) begin
                            state <= D_STB;
                            o_A0  <= 1'b1;
                            o_D   <= head_data;
                        end else begin
                            state      <= A_STB;
                            o_A0       <= 1'b0;
                            o_D        <= head_addr;
                            last_addr  <= head_addr;
                            last_valid <= 1'b1;
                        end
                    end
                end
                A_STB: begin
                    if (cnt == CW'(0)) begin
                        state  <= A_GAP;
                        cnt    <= CW'(ADDR_GAP - 1);
                        o_CS_n <= 1'b1;
                        o_WR_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                A_GAP: begin
                    if (cnt == CW'(0)) begin
                        state  <= D_STB;
                        cnt    <= CW'(STB_W - 1);
                        o_A0   <= 1'b1;
                        o_D    <= cur_data;
                        o_CS_n <= 1'b0;
                        o_WR_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                D_STB: begin
                    if (cnt == CW'(0)) begin
                        state  <= D_BUSY;
                        cnt    <= CW'(BUSY_WAIT - 1);
                        o_CS_n <= 1'b1;
                        o_WR_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                D_BUSY: begin
                    if (cnt == CW'(0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_CS_n <= 1'b1;
                    o_WR_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ika2151_wrseq.sv
// Scoreboard bench for ika2151_wrseq: expected strobes are queued at push time
// and a monitor compares them as the chip bus strobes appear.
module tb_ika2151_wrseq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       free_run;
    logic       pcen_free;
    logic       pcen_man;
    logic       pcen_n;
    logic       valid0;
    logic       valid1;
    logic [7:0] addr;
    logic [7:0] data;

    logic       ready0, busy0, cs0, wr0, a00;
    logic [3:0] level0;
    logic [7:0] d0;
    logic       ready1, busy1, cs1, wr1, a01;
    logic [3:0] level1;
    logic [7:0] d1;

    assign pcen_n = free_run ? pcen_free : pcen_man;

    ika2151_wrseq dut0 (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
        .i_wr_valid(valid0), .o_wr_ready(ready0), .i_wr_addr(addr), .i_wr_data(data),
        .o_level(level0), .o_busy(busy0), .o_CS_n(cs0), .o_WR_n(wr0), .o_A0(a00), .o_D(d0)
    );

    ika2151_wrseq #(.SKIP_SAME_ADDR(1'b0)) dut1 (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
        .i_wr_valid(valid1), .o_wr_ready(ready1), .i_wr_addr(addr), .i_wr_data(data),
        .o_level(level1), .o_busy(busy1), .o_CS_n(cs1), .o_WR_n(wr1), .o_A0(a01), .o_D(d1)
    );

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;

    logic [8:0] exp_q[$];
    bit         m_last_valid = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Model of dut0 (address skip enabled): queue the strobes a pair will produce.
    task automatic expect_pair(input logic [7:0] a, input logic [7:0] d);
        if (!(m_last_valid && (m_last == a))) exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b1, d});
        m_last       = a;
        m_last_valid = 1'b1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        valid0 = 1'b1; addr = a; data = d;
        @(negedge clk);
        valid0 = 1'b0;
        expect_pair(a, d);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while ((busy0 || busy1) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy0 | busy1}, 32'd0);
    endtask

    always @(posedge clk) if (!pcen_n) tick_cnt <= tick_cnt + 1;

    initial begin
        pcen_free = 1'b1;
        forever begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                pcen_free = (i != 3);
            end
        end
    end

    // dut0 monitor: compare every strobe with the scoreboard and check its timing
    logic       prev_cs = 1'b1;
    bit         prev_addr = 1'b0;
    int         fall_t = 0;
    int         rise_t = 0;
    logic [8:0] held = 9'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cs   = cs0;
                prev_addr = 1'b0;
            end else begin
                if (prev_cs && !cs0) begin
                    check("wr_follows_cs_fall", {31'd0, wr0}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got A0=%0d D=0x%0h expected none", a00, d0);
                    end else begin
                        check("strobe_a0_d", {23'd0, a00, d0}, {23'd0, exp_q.pop_front()});
                    end
                    if (a00 && prev_addr) check("addr_gap_ticks", tick_cnt - rise_t, 32'd2);
                    prev_addr = 1'b0;
                    fall_t    = tick_cnt;
                    held      = {a00, d0};
                end else if (!prev_cs && cs0) begin
                    check("wr_follows_cs_rise", {31'd0, wr0}, 32'd1);
                    check("strobe_width_ticks", tick_cnt - fall_t, 32'd2);
                    rise_t    = tick_cnt;
                    prev_addr = !held[8];
                end else if (!cs0) begin
                    check("bus_stable_in_strobe", {23'd0, a00, d0}, {23'd0, held});
                end
                prev_cs = cs0;
            end
        end
    end

    // dut1 monitor: count address and data strobes
    logic prev_cs1 = 1'b1;
    int   cnt_a1 = 0;
    int   cnt_d1 = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && prev_cs1 && !cs1) begin
                if (a01) cnt_d1++;
                else     cnt_a1++;
            end
            prev_cs1 = cs1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; addr = 8'h00; data = 8'h00;
        free_run = 1'b0; pcen_man = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, cs0}, 32'd1);
        check("rst_wr_n", {31'd0, wr0}, 32'd1);
        check("rst_a0", {31'd0, a00}, 32'd0);
        check("rst_d", {24'd0, d0}, 32'd0);
        check("rst_level", {28'd0, level0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;

        // single pair, tick every 4 clocks
        free_run = 1'b1;
        push_pair(8'h20, 8'hC7);
        check("level_after_push", {28'd0, level0}, 32'd1);
        check("busy_after_push", {31'd0, busy0}, 32'd1);
        n = 0;
        while (cs0 && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check("first_strobe_seen", {31'd0, cs0}, 32'd0);
        t0 = tick_cnt;
        wait_idle("single_pair_idle", 1000);
        check("ticks_to_idle", tick_cnt - t0, 32'd74);

        // same address twice: skip on dut0, full pairs on dut1
        @(negedge clk);
        valid0 = 1'b1; valid1 = 1'b1; addr = 8'h08; data = 8'h00;
        expect_pair(8'h08, 8'h00);
        @(negedge clk);
        addr = 8'h08; data = 8'h78;
        expect_pair(8'h08, 8'h78);
        @(negedge clk);
        valid0 = 1'b0; valid1 = 1'b0;
        wait_idle("same_addr_idle", 2000);
        check("noskip_addr_strobes", cnt_a1, 32'd2);
        check("noskip_data_strobes", cnt_d1, 32'd2);

        // ticks stopped: fill the FIFO, nothing moves on the bus
        free_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid0 = 1'b1; addr = 8'h30 + 8'(i); data = 8'hA0 + 8'(i);
            expect_pair(addr, data);
        end
        @(negedge clk);
        valid0 = 1'b0;
        check("full_level", {28'd0, level0}, 32'd8);
        check("full_ready", {31'd0, ready0}, 32'd0);
        repeat (100) @(negedge clk);
        check("hold_cs_n", {31'd0, cs0}, 32'd1);
        check("hold_a0_d", {23'd0, a00, d0}, {23'd0, 1'b1, 8'h78});
        check("hold_level", {28'd0, level0}, 32'd8);
        check("hold_busy", {31'd0, busy0}, 32'd1);

        @(negedge clk);
        valid0 = 1'b1; addr = 8'h99; data = 8'h99;
        @(negedge clk);
        valid0 = 1'b0;
        check("ninth_refused_level", {28'd0, level0}, 32'd8);

        // pop while full: the simultaneous push is still refused
        valid0 = 1'b1; addr = 8'h9A; data = 8'h9A; pcen_man = 1'b0;
        @(negedge clk);
        valid0 = 1'b0; pcen_man = 1'b1;
        check("full_pop_push_level", {28'd0, level0}, 32'd7);
        check("full_pop_ready", {31'd0, ready0}, 32'd1);

        pcen_man = 1'b0;
        repeat (74) @(negedge clk);
        pcen_man = 1'b1;
        check("after_74_ticks_level", {28'd0, level0}, 32'd7);
        check("after_74_ticks_cs", {31'd0, cs0}, 32'd1);

        // pop and push together at level 7
        valid0 = 1'b1; addr = 8'h40; data = 8'h41; pcen_man = 1'b0;
        expect_pair(8'h40, 8'h41);
        @(negedge clk);
        valid0 = 1'b0; pcen_man = 1'b1;
        check("pop_push_level7", {28'd0, level0}, 32'd7);

        // advance into the data strobe, then reset in the middle of it
        pcen_man = 1'b0;
        repeat (4) @(negedge clk);
        pcen_man = 1'b1;
        check("in_d_stb", {22'd0, cs0, a00, d0}, {22'd0, 1'b0, 1'b1, 8'hA1});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_wr", {30'd0, cs0, wr0}, 32'd3);
        check("mid_rst_level", {28'd0, level0}, 32'd0);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_a0_d", {23'd0, a00, d0}, 32'd0);
        exp_q.delete();
        m_last_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        free_run = 1'b1;
        push_pair(8'h31, 8'h55);
        wait_idle("post_rst_idle", 1000);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("dut1_final", {18'd0, ready1, level1, wr1, cs1, d1}, {18'd0, 1'b1, 4'd0, 1'b1, 1'b1, 8'h00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
